// File: rtl/dm_bus_arbiter.sv
// Round-robin arbiter for the shared data-memory port between the CPU M stage
// and a DMA master, with variable-latency req/ack sequencing and timeout abort.
module dm_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic [3:0]  cpu_byteen,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic [31:0] dma_addr,
  input  logic [3:0]  dma_byteen,
  input  logic [31:0] dma_wdata,
  output logic        dma_done,
  output logic [31:0] dma_rdata,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_BUSY = 2'd1,
    DMA_BUSY = 2'd2
  } state_e;

  localparam int unsigned AW = 32;
  localparam int unsigned BW = 4;

  state_e           state_q, state_d;
  logic             last_dma_q, last_dma_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [BW-1:0]    mem_byteen_q, mem_byteen_d;
  logic [AW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [AW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [AW-1:0]    dma_rdata_q, dma_rdata_d;
  logic             dma_done_q, dma_done_d;
  logic             bus_err_q, bus_err_d;

  logic busy;
  logic timeout_hit;
  logic grant_cpu;
  logic grant_dma;

  assign busy        = (state_q != IDLE);
  assign timeout_hit = busy && !mem_ack && (cnt_q == CNT_W'(TIMEOUT - 1));

  // On a tie the side that did not win last time is granted.
  assign grant_cpu = cpu_req && (!dma_req || last_dma_q);
  assign grant_dma = dma_req && (!cpu_req || !last_dma_q);

  assign cpu_stall = cpu_req && !((state_q == CPU_BUSY) && (mem_ack || timeout_hit));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_dma_q   <= 1'b1;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_byteen_q <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
      dma_done_q   <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_dma_q   <= last_dma_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_byteen_q <= mem_byteen_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_done_q   <= dma_done_d;
      bus_err_q    <= bus_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_dma_d   = last_dma_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    mem_byteen_d = mem_byteen_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    dma_done_d   = 1'b0;
    bus_err_d    = bus_err_q;

    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          state_d      = CPU_BUSY;
          last_dma_d   = 1'b0;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_addr_d   = {cpu_addr[31:2], 2'b00};
          mem_byteen_d = cpu_byteen;
          mem_wdata_d  = cpu_wdata;
        end else if (grant_dma) begin
          state_d      = DMA_BUSY;
          last_dma_d   = 1'b1;
          cnt_d        = '0;
          mem_req_d    = 1'b1;
          mem_addr_d   = {dma_addr[31:2], 2'b00};
          mem_byteen_d = dma_byteen;
          mem_wdata_d  = dma_wdata;
        end
      end
      CPU_BUSY, DMA_BUSY: begin
        if (mem_ack || timeout_hit) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          dma_done_d = (state_q == DMA_BUSY);
          // An abort returns zero data; a completed store leaves rdata alone.
          if (timeout_hit) begin
            bus_err_d = 1'b1;
            if (state_q == CPU_BUSY) cpu_rdata_d = '0;
            else                     dma_rdata_d = '0;
          end else if (mem_byteen_q == '0) begin
            if (state_q == CPU_BUSY) cpu_rdata_d = mem_rdata;
            else                     dma_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_byteen = mem_byteen_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rdata  = dma_rdata_q;
  assign dma_done   = dma_done_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Randomized bench for dm_bus_arbiter against a transaction-level reference
// model, plus a few directed scenarios with literal expectations.
module tb_dm_bus_arbiter;

  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 5;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [3:0]  cpu_byteen;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        dma_req;
  logic [31:0] dma_addr;
  logic [3:0]  dma_byteen;
  logic [31:0] dma_wdata;
  logic        dma_done;
  logic [31:0] dma_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byteen;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err;

  dm_bus_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_byteen(dma_byteen),
    .dma_wdata(dma_wdata), .dma_done(dma_done), .dma_rdata(dma_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_byteen(mem_byteen),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the bus, how many cycles its request has been
  // outstanding, and the values the registered outputs should show.
  int          m_owner;   // 0 none, 1 cpu, 2 dma
  int          m_waited;  // busy cycles elapsed including the current one
  int          m_last;    // side granted most recently
  logic        m_req;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic [31:0] m_rd [1:2];
  logic        m_done;
  logic        m_err;

  task automatic model_reset();
    m_owner = 0; m_waited = 0; m_last = 2;
    m_req = 1'b0; m_addr = '0; m_be = '0; m_wdata = '0;
    m_rd[1] = '0; m_rd[2] = '0; m_done = 1'b0; m_err = 1'b0;
  endtask

  function automatic logic exp_stall();
    logic finishing;
    finishing = (m_owner == 1) && (mem_ack || m_waited == TIMEOUT);
    return cpu_req && !finishing;
  endfunction

  task automatic model_step();
    int g;
    if (!reset) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (m_owner == 0) begin
      g = 0;
      if (cpu_req && dma_req) g = (m_last == 1) ? 2 : 1;
      else if (cpu_req)       g = 1;
      else if (dma_req)       g = 2;
      if (g != 0) begin
        m_owner = g; m_last = g; m_waited = 1; m_req = 1'b1;
        m_addr  = ((g == 1) ? cpu_addr : dma_addr) & 32'hFFFF_FFFC;
        m_be    = (g == 1) ? cpu_byteen : dma_byteen;
        m_wdata = (g == 1) ? cpu_wdata  : dma_wdata;
      end
    end else if (mem_ack || m_waited == TIMEOUT) begin
      if (!mem_ack) begin
        m_err = 1'b1;
        m_rd[m_owner] = '0;
      end else if (m_be == 4'b0000) begin
        m_rd[m_owner] = mem_rdata;
      end
      m_done  = (m_owner == 2);
      m_req   = 1'b0;
      m_owner = 0;
    end else begin
      m_waited++;
    end
  endtask

  // One clock: inputs are driven after the falling edge, the combinational stall
  // is checked before the rising edge and the registered outputs just after it.
  task automatic tick();
    #1;
    check_eq("cpu_stall", 32'(cpu_stall), 32'(exp_stall()));
    @(posedge clk);
    model_step();
    #1;
    check_eq("mem_req",    32'(mem_req),    32'(m_req));
    check_eq("mem_addr",   mem_addr,        m_addr);
    check_eq("mem_byteen", 32'(mem_byteen), 32'(m_be));
    check_eq("mem_wdata",  mem_wdata,       m_wdata);
    check_eq("cpu_rdata",  cpu_rdata,       m_rd[1]);
    check_eq("dma_rdata",  dma_rdata,       m_rd[2]);
    check_eq("dma_done",   32'(dma_done),   32'(m_done));
    check_eq("bus_err",    32'(bus_err),    32'(m_err));
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; cpu_addr = '0; cpu_byteen = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0; dma_byteen = '0; dma_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  int stall_cnt;
  int ack_pct;

  initial begin
    checks = 0;
    failures = 0;
    model_reset();
    reset = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();
    check_eq("reset_mem_req", 32'(mem_req), 32'd0);
    check_eq("reset_bus_err", 32'(bus_err), 32'd0);

    // CPU load at an unaligned address, ack on the third cycle of mem_req.
    cpu_req = 1'b1; cpu_addr = 32'h0000_1006; cpu_byteen = 4'b0000;
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = (i == 3);
      mem_rdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0;
      if (i == 1) check_eq("load_mem_addr", mem_addr, 32'h0000_1004);
      #1;
      if (cpu_stall) stall_cnt++;
      tick();
    end
    check_eq("load_stall_cycles", 32'(stall_cnt), 32'd3);
    cpu_req = 1'b0; mem_ack = 1'b0;
    check_eq("load_rdata", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // CPU store with immediate ack leaves cpu_rdata alone.
    cpu_req = 1'b1; cpu_addr = 32'h0000_2000; cpu_byteen = 4'b0100; cpu_wdata = 32'h00AB_0000;
    tick();
    check_eq("store_byteen", 32'(mem_byteen), 32'h4);
    check_eq("store_wdata", mem_wdata, 32'h00AB_0000);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    cpu_req = 1'b0; mem_ack = 1'b0;
    check_eq("store_rdata_kept", cpu_rdata, 32'hDEAD_BEEF);
    tick();

    // Hung CPU load: abort after TIMEOUT cycles, sticky error, zero data.
    cpu_req = 1'b1; cpu_addr = 32'h0000_3000; cpu_byteen = 4'b0000;
    for (int i = 0; i < TIMEOUT + 1; i++) tick();
    cpu_req = 1'b0;
    check_eq("tmo_mem_req", 32'(mem_req), 32'd0);
    check_eq("tmo_bus_err", 32'(bus_err), 32'd1);
    check_eq("tmo_rdata", cpu_rdata, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check_eq("tmo_err_sticky", 32'(bus_err), 32'd1);
    do_reset();

    // Randomized phases with different memory responsiveness.
    for (int p = 0; p < 4; p++) begin
      ack_pct = (p == 0) ? 50 : (p == 1) ? 2 : (p == 2) ? 100 : 25;
      for (int c = 0; c < 500; c++) begin
        reset = ($urandom_range(0, 199) != 0);
        cpu_req = ($urandom_range(0, 99) < 60);
        cpu_addr = $urandom; cpu_wdata = $urandom;
        cpu_byteen = ($urandom_range(0, 1) != 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        // The DMA master holds its request and payload until it sees dma_done.
        if (dma_done || !reset) dma_req = 1'b0;
        else if (!dma_req && $urandom_range(0, 99) < 40) begin
          dma_req = 1'b1; dma_addr = $urandom; dma_wdata = $urandom;
          dma_byteen = ($urandom_range(0, 1) != 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        end
        mem_ack = ($urandom_range(0, 99) < ack_pct);
        mem_rdata = $urandom;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
